// File: rtl/seq_sync_detector.sv
// Serial frame-pattern detector with HUNT/CONFIRM/LOCK sync tracking.
// Consumes one bit per enabled clock and counts matches and missed frame slots.
module seq_sync_detector #(
    parameter int                 PAT_LEN = 8,
    parameter logic [PAT_LEN-1:0] PATTERN = 8'b01011010,
    parameter int                 LOCK_N  = 3,
    parameter int                 LOSS_N  = 2,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_en,
    input  logic             cnt_clr,
    output logic             match,
    output logic             locked,
    output logic [1:0]       sync_state,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PH_W = $clog2(PAT_LEN);
    localparam int FL_W = $clog2(PAT_LEN + 1);
    localparam int CF_W = $clog2(LOCK_N + 1);
    localparam int MS_W = $clog2(LOSS_N + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        CONFIRM = 2'b01,
        LOCK    = 2'b10
    } state_t;

    state_t             r_state;
    logic [PAT_LEN-1:0] r_win;
    logic [FL_W-1:0]    r_fill;
    logic [PH_W-1:0]    r_phase;
    logic [CF_W-1:0]    r_conf;
    logic [MS_W-1:0]    r_miss;
    logic               r_match;
    logic [CNT_W-1:0]   r_match_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic [PAT_LEN-1:0] w_win_nxt;
    logic               w_fill_ok;
    logic               w_hit;
    logic               w_slot;
    logic               w_err;
    logic [CF_W-1:0]    w_conf_inc;
    logic [MS_W-1:0]    w_miss_inc;

    // The incoming bit counts toward both the window and the fill check.
    always_comb begin
        w_win_nxt  = {r_win[PAT_LEN-2:0], din};
        w_fill_ok  = (r_fill >= FL_W'(PAT_LEN - 1));
        w_hit      = din_en && w_fill_ok && (w_win_nxt == PATTERN);
        w_slot     = din_en && (r_phase == PH_W'(PAT_LEN - 1));
        w_err      = w_slot && !w_hit && (r_state == LOCK);
        w_conf_inc = r_conf + CF_W'(1);
        w_miss_inc = r_miss + MS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_win   <= '0;
            r_fill  <= '0;
            r_phase <= '0;
            r_conf  <= '0;
            r_miss  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (din_en) begin
                r_win <= w_win_nxt;
                if (r_fill != FL_W'(PAT_LEN))
                    r_fill <= r_fill + FL_W'(1);
            end
            case (r_state)
                HUNT: begin
                    if (w_hit) begin
                        r_phase <= '0;
                        r_conf  <= CF_W'(1);
                        r_miss  <= '0;
                        r_state <= (LOCK_N <= 1) ? LOCK : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (w_slot) begin
                        r_phase <= '0;
                        if (w_hit) begin
                            r_conf <= w_conf_inc;
                            if (w_conf_inc >= CF_W'(LOCK_N)) begin
                                r_state <= LOCK;
                                r_miss  <= '0;
                            end
                        end else begin
                            r_state <= HUNT;
                            r_conf  <= '0;
                        end
                    end else if (din_en) begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                LOCK: begin
                    // Flywheel: the slot grid advances whether or not the slot hit.
                    if (w_slot) begin
                        r_phase <= '0;
                        if (w_hit) begin
                            r_miss <= '0;
                        end else if (w_miss_inc >= MS_W'(LOSS_N)) begin
                            r_state <= HUNT;
                            r_conf  <= '0;
                            r_miss  <= '0;
                        end else begin
                            r_miss <= w_miss_inc;
                        end
                    end else if (din_en) begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                default: begin
                    r_state <= HUNT;
                    r_phase <= '0;
                    r_conf  <= '0;
                    r_miss  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (cnt_clr)
                r_match_cnt <= '0;
            else if (w_hit && (r_match_cnt != '1))
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            if (cnt_clr)
                r_err_cnt <= '0;
            else if (w_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign match      = r_match;
    assign locked     = (r_state == LOCK);
    assign sync_state = r_state;
    assign match_cnt  = r_match_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_seq_sync_detector.sv
// Scoreboard bench for seq_sync_detector: the driver queues hand-computed
// expectations, the monitor pops one per match pulse (or per immediate check).
module tb_seq_sync_detector;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_en;
    logic       cnt_clr;
    logic       match, locked;
    logic [1:0] sync_state;
    logic [7:0] match_cnt, err_cnt;
    logic       m2, lk2;
    logic [1:0] st2;
    logic [1:0] mc2, ec2;

    seq_sync_detector u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .cnt_clr(cnt_clr),
        .match(match), .locked(locked), .sync_state(sync_state),
        .match_cnt(match_cnt), .err_cnt(err_cnt)
    );

    seq_sync_detector #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .cnt_clr(cnt_clr),
        .match(m2), .locked(lk2), .sync_state(st2),
        .match_cnt(mc2), .err_cnt(ec2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        bit         on_match;
        logic [1:0] st;
        bit         lk;
        int         mc;
        int         ec;
        int         mc2;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_m   = 0;
    int   rec_id   = 0;
    bit   done     = 1'b0;

    localparam logic [7:0] G = 8'b01011010;
    localparam logic [7:0] X = 8'b01011011;

    // Monitor: pops a match record on each pulse, or an immediate record at once.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        int   ec2_exp;
        cyc++;
        if (q.size() > 0 && (!q[0].on_match || match)) begin
            e       = q.pop_front();
            ec2_exp = (e.ec > 3) ? 3 : e.ec;
            ok = (match == e.on_match) && (sync_state == e.st) && (locked == e.lk) &&
                 (int'(match_cnt) == e.mc) && (int'(err_cnt) == e.ec) &&
                 (m2 == e.on_match) && (st2 == e.st) && (lk2 == e.lk) &&
                 (int'(mc2) == e.mc2) && (int'(ec2) == ec2_exp);
            if (e.on_match && e.gap != 0 && (cyc - last_m) != e.gap) ok = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rec%0d: got m=%0d st=%0d lk=%0d mc=%0d ec=%0d m2=%0d st2=%0d mc2=%0d ec2=%0d gap=%0d; want m=%0d st=%0d lk=%0d mc=%0d ec=%0d mc2=%0d ec2=%0d gap=%0d",
                         e.id, match, sync_state, locked, match_cnt, err_cnt, m2, st2, mc2, ec2,
                         cyc - last_m, e.on_match, e.st, e.lk, e.mc, e.ec, e.mc2, ec2_exp, e.gap);
            end
        end else if (match || m2) begin
            checks++;
            failures++;
            $display("FAIL unexpected_match: got match=%0d m2=%0d at cycle %0d, want no pulse",
                     match, m2, cyc);
        end
        if (match) last_m = cyc;
        if (done) begin
            checks++;
            if (q.size() != 0) begin
                failures++;
                $display("FAIL pending_records: got %0d left, want 0", q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish within 100000 time units");
        $fatal(1);
    end

    task automatic ex(input bit om, input logic [1:0] st, input bit lk,
                      input int mc, input int ec, input int mcb, input int gap);
        exp_t e;
        rec_id++;
        e.id = rec_id; e.on_match = om; e.st = st; e.lk = lk;
        e.mc = mc; e.ec = ec; e.mc2 = mcb; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic bit1(input logic b, input logic en, input logic clr);
        din = b; din_en = en; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] f, input bit tog, input bit clr_last);
        for (int i = 7; i >= 0; i--) begin
            bit1(f[i], 1'b1, clr_last && (i == 0));
            if (tog) bit1(~f[i], 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; din = 1'b0; din_en = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ex(0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk); #1 rst_n = 1'b1;

        // Acquire: CONFIRM after 1st match, LOCK after 3rd; cnt_w=2 copy saturates.
        ex(1, 2'b01, 0, 1, 0, 1, 0);  frame(G, 0, 0);
        ex(1, 2'b01, 0, 2, 0, 2, 8);  frame(G, 0, 0);
        ex(1, 2'b10, 1, 3, 0, 3, 8);  frame(G, 0, 0);
        ex(1, 2'b10, 1, 4, 0, 3, 8);  frame(G, 0, 0);
        ex(1, 2'b10, 1, 5, 0, 3, 8);  frame(G, 0, 0);

        // Lone bad frame keeps lock; the good frame between resets the miss count.
        frame(X, 0, 0);  ex(0, 2'b10, 1, 5, 1, 3, 0);
        ex(1, 2'b10, 1, 6, 1, 3, 16); frame(G, 0, 0);
        frame(X, 0, 0);  ex(0, 2'b10, 1, 6, 2, 3, 0);
        ex(1, 2'b10, 1, 7, 2, 3, 16); frame(G, 0, 0);

        // Two bad frames in a row drop to HUNT, then relock after three matches.
        frame(X, 0, 0);  ex(0, 2'b10, 1, 7, 3, 3, 0);
        frame(X, 0, 0);  ex(0, 2'b00, 0, 7, 4, 3, 0);
        ex(1, 2'b01, 0, 8, 4, 3, 24);  frame(G, 0, 0);
        ex(1, 2'b01, 0, 9, 4, 3, 8);   frame(G, 0, 0);
        ex(1, 2'b10, 1, 10, 4, 3, 8);  frame(G, 0, 0);

        // Bad second frame while confirming falls back to HUNT without an error count.
        frame(X, 0, 0);  ex(0, 2'b10, 1, 10, 5, 3, 0);
        frame(X, 0, 0);  ex(0, 2'b00, 0, 10, 6, 3, 0);
        ex(1, 2'b01, 0, 11, 6, 3, 24); frame(G, 0, 0);
        frame(X, 0, 0);  ex(0, 2'b00, 0, 11, 6, 3, 0);
        ex(1, 2'b01, 0, 12, 6, 3, 16); frame(G, 0, 0);
        ex(1, 2'b01, 0, 13, 6, 3, 8);  frame(G, 0, 0);
        ex(1, 2'b10, 1, 14, 6, 3, 8);  frame(G, 0, 0);

        // Mid-frame async reset; the stale '0' must not complete a pattern afterwards.
        bit1(1'b0, 1'b1, 1'b0); bit1(1'b1, 1'b1, 1'b0); bit1(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0; din_en = 1'b0;
        ex(0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        frame(8'b1011_0101, 0, 0);
        ex(0, 2'b00, 0, 0, 0, 0, 0);

        // Half-rate enable: matches every 16 clocks, lock still reached.
        ex(1, 2'b01, 0, 1, 0, 1, 0);   frame(G, 1, 0);
        ex(1, 2'b01, 0, 2, 0, 2, 16);  frame(G, 1, 0);
        ex(1, 2'b10, 1, 3, 0, 3, 16);  frame(G, 1, 0);

        // cnt_clr on a hit edge wins over the increment.
        frame(X, 0, 0);  ex(0, 2'b10, 1, 3, 1, 3, 0);
        ex(1, 2'b10, 1, 0, 0, 0, 17);  frame(G, 0, 1);
        ex(1, 2'b10, 1, 1, 0, 1, 8);   frame(G, 0, 0);

        din_en = 1'b0;
        done = 1'b1;
    end

endmodule
